// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the fetch controller and its output buffer.
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    DROP,
    HOLD,
    IDLE
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_out_buf.sv
// IF/ID output register plus a one-entry skid that parks a response arriving while decode stalls.
module fetch_out_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        consume_i,
  input  logic        load_i,
  input  logic [31:0] load_instr_i,
  input  logic [31:0] load_pc_i,
  input  logic        load_fault_i,
  input  logic        skid_wr_i,
  input  logic [31:0] skid_instr_i,
  input  logic [31:0] skid_pc_i,
  input  logic        skid_pop_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic        skid_valid_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        skv_q, skv_d;
  logic [31:0] ski_q, ski_d;
  logic [31:0] skp_q, skp_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    skv_d   = skv_q;
    ski_d   = ski_q;
    skp_d   = skp_q;

    if (consume_i || clear_i) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end
    if (clear_i) begin
      skv_d = 1'b0;
    end

    // A fresh load (including the fault NOP on a flush) wins over draining the skid.
    if (load_i) begin
      valid_d = 1'b1;
      instr_d = load_instr_i;
      pc_d    = load_pc_i;
      fault_d = load_fault_i;
    end else if (skid_pop_i && skv_q) begin
      valid_d = 1'b1;
      instr_d = ski_q;
      pc_d    = skp_q;
      fault_d = 1'b0;
      skv_d   = 1'b0;
    end

    if (skid_wr_i) begin
      skv_d = 1'b1;
      ski_d = skid_instr_i;
      skp_d = skid_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      fault_q <= 1'b0;
      skv_q   <= 1'b0;
      ski_q   <= 32'h0;
      skp_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      skv_q   <= skv_d;
      ski_q   <= ski_d;
      skp_q   <= skp_d;
    end
  end

  assign valid_o      = valid_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_q;
  assign fault_o      = fault_q;
  assign skid_valid_o = skv_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, single-outstanding imem req/gnt/rvalid handshake, stall and redirect handling.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_pend_q, fault_pend_d;

  logic [31:0]  redir_tgt;
  logic         redir_misalign;
  logic [31:0]  pc_inc;
  logic         slot_free;
  fetch_state_t resume_st;

  logic         req;
  logic         buf_clear;
  logic         buf_load;
  logic [31:0]  load_instr;
  logic [31:0]  load_pc;
  logic         load_fault;
  logic         skid_wr;
  logic         skid_pop;
  logic         skid_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_tgt      = redirect_pc;
  assign redir_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_tgt      = redirect_pc & ~32'h3;
  assign redir_misalign = 1'b0;
`endif

  assign pc_inc    = pc_q + PC_STEP;
  assign slot_free = !if_valid || !stall_i;
  assign resume_st = redir_misalign ? IDLE : REQ;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_pend_d = fault_pend_q;
    req          = (state_q == REQ);
    buf_clear    = 1'b0;
    buf_load     = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = pc_q;
    load_fault   = 1'b0;
    skid_wr      = 1'b0;
    skid_pop     = 1'b0;

    if (redirect_valid) begin
      pc_d         = redir_tgt;
      buf_clear    = 1'b1;
      fault_pend_d = redir_misalign;
      if (redir_misalign) begin
        buf_load   = 1'b1;
        load_instr = NOP_INSTR;
        load_pc    = redir_tgt;
        load_fault = 1'b1;
      end
      // A granted or still-pending request leaves a response in flight that must be drained.
      case (state_q)
        REQ:     state_d = imem_gnt ? DROP : resume_st;
        WAIT:    state_d = imem_rvalid ? resume_st : DROP;
        DROP:    state_d = imem_rvalid ? resume_st : DROP;
        default: state_d = resume_st;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (imem_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            pc_d = pc_inc;
            if (slot_free) begin
              buf_load = 1'b1;
              state_d  = REQ;
            end else begin
              skid_wr = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            skid_pop = 1'b1;
            state_d  = REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_d      = fault_pend_q ? IDLE : REQ;
            fault_pend_d = 1'b0;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  // The reset state is REQ, so the request is masked while reset is held.
  assign imem_req  = req && rst;
  assign imem_addr = pc_q;

  fetch_out_buf u_out_buf (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (buf_clear),
    .consume_i    (!stall_i),
    .load_i       (buf_load),
    .load_instr_i (load_instr),
    .load_pc_i    (load_pc),
    .load_fault_i (load_fault),
    .skid_wr_i    (skid_wr),
    .skid_instr_i (imem_rdata),
    .skid_pc_i    (pc_q),
    .skid_pop_i   (skid_pop),
    .valid_o      (if_valid),
    .instr_o      (if_instr),
    .pc_o         (if_pc),
    .fault_o      (if_fault),
    .skid_valid_o (skid_valid)
  );

`ifndef SYNTHESIS
  rvalid_in_window: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (state_q == WAIT || state_q == DROP));

  addr_stable_until_gnt: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_gnt && !redirect_valid) |=> (imem_req && $stable(imem_addr)));

  skid_only_in_hold: assert property (@(posedge clk) disable iff (!rst)
    skid_valid |-> (state_q == HOLD));
`endif

endmodule
